data_memory_bank: RTL and testbench

Parametrised single-port synchronous data memory, the successor to the fixed 256x32 data memory. It adds width, depth and byte-lane generalisation, per-byte write enables, a registered read-valid strobe, and out-of-range address detection. It also provides a hardware clear sequencer that zeroes the array after reset or on request, replacing simulation-only initialisation. It sits on the processor datapath as the load/store target.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_clear_ctrl.sv | 69 ++++++
 rtl/data_memory_bank.sv | 100 ++++++++++
 tb/tb_data_memory_bank.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised data memory bank.
// Holds the clear-sequencer state type and lane-count helper.
package mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_BYTE_W = 8;
    localparam int DEF_DEPTH  = 256;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    function automatic int nbytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Clear sequencer: walks every word writing zero after reset or
// on request, then reports ready. Pointer stops at DEPTH-1.
module mem_clear_ctrl
    import mem_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          clr_we,
    output logic [PW-1:0] clr_addr,
    output logic          ready,
    output logic          busy
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    mem_state_t    r_state;
    mem_state_t    w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    // State and pointer registers; reset restarts the sweep at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state: sweep until the last word, clr only honoured when ready.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            CLEAR: begin
                if (r_ptr == LAST) begin
                    w_state_nxt = READY;
                end else begin
                    w_ptr_nxt = r_ptr + PW'(1);
                end
            end
            READY: begin
                if (clr) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        clr_we   = (r_state == CLEAR);
        busy     = (r_state == CLEAR);
        ready    = (r_state == READY);
        clr_addr = r_ptr;
    end

endmodule

// File: rtl/data_memory_bank.sv
// Single-port synchronous data memory with byte-lane writes,
// registered read-valid, range detection and hardware clear.
module data_memory_bank
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       wen,
    input  logic [nbytes(DATA_W, BYTE_W)-1:0] be,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       clr,
    output logic [DATA_W-1:0]          data_out,
    output logic                       rd_valid,
    output logic                       busy,
    output logic                       addr_err
);

    localparam int NB = nbytes(DATA_W, BYTE_W);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W) || (DATA_W % BYTE_W) != 0) begin : g_bad_params
        $error("data_memory_bank: illegal DEPTH/ADDR_W/DATA_W/BYTE_W");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic          w_clr_we;
    logic [PW-1:0] w_clr_addr;
    logic          w_ready;
    logic [IW-1:0] w_clr_idx;
    logic [IW-1:0] w_addr_idx;
    logic [ADDR_W:0] w_addr_ext;
    logic          w_oor;
    logic          w_acc;
    logic          w_unused;

    mem_clear_ctrl #(
        .DEPTH(DEPTH)
    ) u_clear (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .clr_we  (w_clr_we),
        .clr_addr(w_clr_addr),
        .ready   (w_ready),
        .busy    (busy)
    );

    assign w_clr_idx  = w_clr_addr[IW-1:0];
    assign w_addr_idx = addr[IW-1:0];
    assign w_addr_ext = {1'b0, addr};
    assign w_oor      = (w_addr_ext >= (ADDR_W + 1)'(DEPTH));
    assign w_acc      = w_ready && !clr && en;
    assign w_unused   = ^{w_clr_addr, addr};

    // Array write port: clear sweep wins, else byte-lane merged user write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[w_clr_idx] <= '0;
            end else if (w_acc && wen && !w_oor) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        r_mem[w_addr_idx][i*BYTE_W +: BYTE_W] <=
                            data_in[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // Output registers: read data, valid strobe and range error pulse.
    always_ff @(posedge clk) begin
        if (rst || !w_ready || clr) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else if (en && wen) begin
            rd_valid <= 1'b0;
            addr_err <= w_oor;
        end else if (en) begin
            data_out <= w_oor ? '0 : r_mem[w_addr_idx];
            rd_valid <= 1'b1;
            addr_err <= w_oor;
        end else begin
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_memory_bank.sv
// Self-checking bench for data_memory_bank: reference model with
// random traffic, directed clear sequences, and a DEPTH=200 vector table.
module tb_data_memory_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, wen, clr;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        rd_valid, busy, addr_err;

    logic        rst2, en2, wen2, clr2;
    logic [3:0]  be2;
    logic [7:0]  addr2;
    logic [31:0] data_in2;
    logic [31:0] data_out2;
    logic        rd_valid2, busy2, addr_err2;

    data_memory_bank u_dut (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .be(be),
        .addr(addr), .data_in(data_in), .clr(clr),
        .data_out(data_out), .rd_valid(rd_valid),
        .busy(busy), .addr_err(addr_err)
    );

    data_memory_bank #(.DEPTH(200)) u_dut200 (
        .clk(clk), .rst(rst2), .en(en2), .wen(wen2), .be(be2),
        .addr(addr2), .data_in(data_in2), .clr(clr2),
        .data_out(data_out2), .rd_valid(rd_valid2),
        .busy(busy2), .addr_err(addr_err2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: memory image, busy cycles left, expected outputs.
    logic [31:0] m_mem [256];
    logic [31:0] m_do;
    logic        m_rv, m_err;
    int          m_busy_left = 0;

    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++)
            if (b[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    task automatic start_clear();
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        m_busy_left = 256;
        m_do = 32'h0; m_rv = 1'b0; m_err = 1'b0;
    endtask

    task automatic step(input string tag);
        logic [31:0] mk;
        if (rst) begin
            start_clear();
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            m_do = 32'h0; m_rv = 1'b0; m_err = 1'b0;
        end else if (clr) begin
            start_clear();
        end else if (en && wen) begin
            mk = lane_mask(be);
            m_mem[addr] = (m_mem[addr] & ~mk) | (data_in & mk);
            m_rv = 1'b0; m_err = 1'b0;
        end else if (en) begin
            m_do = m_mem[addr]; m_rv = 1'b1; m_err = 1'b0;
        end else begin
            m_do = 32'h0; m_rv = 1'b0; m_err = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".data_out"}, data_out, m_do);
        chk({tag, ".rd_valid"}, {31'h0, rd_valid}, {31'h0, m_rv});
        chk({tag, ".addr_err"}, {31'h0, addr_err}, {31'h0, m_err});
        chk({tag, ".busy"}, {31'h0, busy}, {31'h0, (m_busy_left > 0)});
    endtask

    task automatic idle();
        en = 1'b0; wen = 1'b0; clr = 1'b0; rst = 1'b0;
        be = 4'h0; addr = 8'h0; data_in = 32'h0;
    endtask

    task automatic run_clear(input string nm);
        int cnt;
        int guard;
        cnt = busy ? 1 : 0;
        guard = 0;
        idle();
        while (busy && guard < 1000) begin
            step(nm);
            if (busy) cnt++;
            guard++;
        end
        chk({nm, ".busy_len"}, cnt, 256);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        idle(); en = 1'b1; wen = 1'b1; addr = a; data_in = d; be = b;
        step("wr");
    endtask

    task automatic rd(input logic [7:0] a, input string nm, input logic [31:0] exp);
        idle(); en = 1'b1; wen = 1'b0; addr = a; be = 4'h0;
        step(nm);
        chk({nm, ".rdata"}, data_out, exp);
        chk({nm, ".rvalid"}, {31'h0, rd_valid}, 32'h1);
    endtask

    typedef struct {
        logic        en;
        logic        wen;
        logic [3:0]  be;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_do;
        logic        exp_rv;
        logic        exp_err;
    } vec_t;

    vec_t tv [10];

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        m_do = 32'h0; m_rv = 1'b0; m_err = 1'b0;
        idle();
        rst2 = 1'b1; en2 = 1'b0; wen2 = 1'b0; clr2 = 1'b0;
        be2 = 4'h0; addr2 = 8'h0; data_in2 = 32'h0;

        // Reset and initial clear sweep.
        rst = 1'b1;
        step("reset");
        chk("reset.busy", {31'h0, busy}, 32'h1);
        run_clear("init");

        rd(8'h00, "rd00", 32'h0);
        rd(8'h7F, "rd7f", 32'h0);
        rd(8'hFF, "rdff", 32'h0);

        // Full write, read back, then idle clears data_out.
        wr(8'h10, 32'hDEADBEEF, 4'hF);
        rd(8'h10, "rd10", 32'hDEADBEEF);
        idle();
        step("idle");
        chk("idle.data_out", data_out, 32'h0);
        chk("idle.rd_valid", {31'h0, rd_valid}, 32'h0);

        // Partial byte-lane write.
        wr(8'h10, 32'h11223344, 4'b0101);
        rd(8'h10, "partial", 32'hDE22BE44);

        // Clear request drops a same-cycle write.
        wr(8'h20, 32'hA5A5A5A5, 4'hF);
        idle(); clr = 1'b1; en = 1'b1; wen = 1'b1;
        addr = 8'h21; data_in = 32'h1; be = 4'hF;
        step("clrreq");
        chk("clrreq.busy", {31'h0, busy}, 32'h1);
        run_clear("clr");
        rd(8'h20, "clr20", 32'h0);
        rd(8'h21, "clr21", 32'h0);

        // Reset at clear cycle 100 restarts the full sweep.
        wr(8'h33, 32'h0BADF00D, 4'hF);
        idle(); clr = 1'b1;
        step("clr2");
        idle();
        for (int i = 0; i < 99; i++) step("mid");
        rst = 1'b1;
        step("midrst");
        run_clear("midclr");
        for (int i = 0; i < 256; i++) begin
            idle(); en = 1'b1; addr = 8'(i);
            step("sweep");
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 799) == 0);
            clr = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 3) != 0);
            wen = 1'($urandom_range(0, 1));
            be = 4'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            data_in = $urandom;
            step("rand");
        end
        idle();

        // DEPTH=200 instance: clear length and range handling.
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        begin
            int cnt2;
            int g2;
            cnt2 = busy2 ? 1 : 0;
            g2 = 0;
            while (busy2 && g2 < 1000) begin
                @(posedge clk); #1;
                if (busy2) cnt2++;
                g2++;
            end
            chk("d200.busy_len", cnt2, 200);
        end

        tv[0] = '{1'b1, 1'b1, 4'hF, 8'd210, 32'h5,        32'h0,        1'b0, 1'b1};
        tv[1] = '{1'b1, 1'b0, 4'hF, 8'd210, 32'h0,        32'h0,        1'b1, 1'b1};
        tv[2] = '{1'b1, 1'b1, 4'hF, 8'd199, 32'h12345678, 32'h0,        1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 4'h0, 8'd199, 32'h0,        32'h12345678, 1'b1, 1'b0};
        tv[4] = '{1'b1, 1'b1, 4'h2, 8'd199, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b0, 4'h0, 8'd199, 32'h0,        32'h1234FF78, 1'b1, 1'b0};
        tv[6] = '{1'b0, 1'b0, 4'h0, 8'd199, 32'h0,        32'h0,        1'b0, 1'b0};
        tv[7] = '{1'b1, 1'b0, 4'h0, 8'd255, 32'h0,        32'h0,        1'b1, 1'b1};
        tv[8] = '{1'b1, 1'b1, 4'hF, 8'd200, 32'h7,        32'h0,        1'b0, 1'b1};
        tv[9] = '{1'b1, 1'b0, 4'h0, 8'd0,   32'h0,        32'h0,        1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            en2 = tv[i].en; wen2 = tv[i].wen; be2 = tv[i].be;
            addr2 = tv[i].addr; data_in2 = tv[i].din;
            @(posedge clk); #1;
            chk($sformatf("d200[%0d].data_out", i), data_out2, tv[i].exp_do);
            chk($sformatf("d200[%0d].rd_valid", i), {31'h0, rd_valid2}, {31'h0, tv[i].exp_rv});
            chk($sformatf("d200[%0d].addr_err", i), {31'h0, addr_err2}, {31'h0, tv[i].exp_err});
        end
        en2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
